// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
//
// Decode-to-execute pipeline register for the RV32I core. It captures the
// decoded operands and control fields from the decode stage, applies EX/MEM
// and MEM/WB operand forwarding to the stored rs1/rs2 values, and presents the
// ALU with its two operands plus ALUCtrl and Flagsel.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   id_valid_i / id_ready_o     decode handshake (ready = !stall_i)
//   id_pc_i, id_imm_i           instruction PC and sign-extended immediate
//   id_rs1/rs2_data_i           register-file read data
//   id_rs1/rs2/rd_addr_i        register addresses
//   id_srca_pc_i, id_srcb_imm_i operand source selects
//   id_aluctrl_i, id_flagsel_i  ALU operation and branch-condition select
//   id_regwrite_i, id_branch_i  writeback enable, conditional branch
//   exmem_*, memwb_*            forwarding sources (write enable, rd, data)
//   stall_i, flush_i            hold / bubble insertion from hazard logic
//   ex_*                        execute-stage view of the held instruction
// -----------------------------------------------------------------------------
module id_ex_pipe #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [RA_W-1:0] id_rs1_addr_i,
    input  logic [RA_W-1:0] id_rs2_addr_i,
    input  logic [RA_W-1:0] id_rd_addr_i,
    input  logic            id_srca_pc_i,
    input  logic            id_srcb_imm_i,
    input  logic [3:0]      id_aluctrl_i,
    input  logic [2:0]      id_flagsel_i,
    input  logic            id_regwrite_i,
    input  logic            id_branch_i,

    input  logic            exmem_regwrite_i,
    input  logic [RA_W-1:0] exmem_rd_i,
    input  logic [XLEN-1:0] exmem_data_i,
    input  logic            memwb_regwrite_i,
    input  logic [RA_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0] memwb_data_i,

    input  logic            stall_i,
    input  logic            flush_i,

    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_opa_o,
    output logic [XLEN-1:0] ex_opb_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [3:0]      ex_aluctrl_o,
    output logic [2:0]      ex_flagsel_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [RA_W-1:0] ex_rd_o,
    output logic            ex_regwrite_o,
    output logic            ex_branch_o
);

    // -------------------------------------------------------------------------
    // Forwarding selection for one source operand. EX/MEM is the younger
    // producer and therefore wins over MEM/WB; x0 is hard-wired zero and is
    // never forwarded, whatever a producer claims to write to it.
    // -------------------------------------------------------------------------
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RA_W-1:0] addr,
        input logic [XLEN-1:0] stored,
        input logic            exmem_we,
        input logic [RA_W-1:0] exmem_rd,
        input logic [XLEN-1:0] exmem_data,
        input logic            memwb_we,
        input logic [RA_W-1:0] memwb_rd,
        input logic [XLEN-1:0] memwb_data
    );
        logic [XLEN-1:0] result;
        logic            addr_nz;
        addr_nz = (addr != {RA_W{1'b0}});
        if (exmem_we && addr_nz && (exmem_rd == addr)) begin
            result = exmem_data;
        end else if (memwb_we && addr_nz && (memwb_rd == addr)) begin
            result = memwb_data;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    // Stored pipeline fields
    logic            valid_q,    valid_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [RA_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [RA_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [RA_W-1:0] rd_q,       rd_d;
    logic            srca_pc_q,  srca_pc_d;
    logic            srcb_imm_q, srcb_imm_d;
    logic [3:0]      aluctrl_q,  aluctrl_d;
    logic [2:0]      flagsel_q,  flagsel_d;
    logic            regwrite_q, regwrite_d;
    logic            branch_q,   branch_d;

    // Forwarded operand values
    logic [XLEN-1:0] fwd_rs1_s;
    logic [XLEN-1:0] fwd_rs2_s;

    // Forwarding network applied to the stored rs1/rs2 operands
    always_comb begin
        fwd_rs1_s = fwd_sel(rs1_addr_q, rs1_data_q,
                            exmem_regwrite_i, exmem_rd_i, exmem_data_i,
                            memwb_regwrite_i, memwb_rd_i, memwb_data_i);
        fwd_rs2_s = fwd_sel(rs2_addr_q, rs2_data_q,
                            exmem_regwrite_i, exmem_rd_i, exmem_data_i,
                            memwb_regwrite_i, memwb_rd_i, memwb_data_i);
    end

    // Next-state selection: flush beats stall, stall beats load
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_d       = rd_q;
        srca_pc_d  = srca_pc_q;
        srcb_imm_d = srcb_imm_q;
        aluctrl_d  = aluctrl_q;
        flagsel_d  = flagsel_q;
        regwrite_d = regwrite_q;
        branch_d   = branch_q;

        if (flush_i) begin
            // Only valid matters; the remaining fields are masked by it.
            valid_d = 1'b0;
        end else if (stall_i) begin
            // A producer may retire while we are held; capture its result
            // now, otherwise it leaves the forwarding window and is lost.
            if (valid_q) begin
                rs1_data_d = fwd_rs1_s;
                rs2_data_d = fwd_rs2_s;
            end else begin
                rs1_data_d = rs1_data_q;
                rs2_data_d = rs2_data_q;
            end
        end else begin
            valid_d    = id_valid_i;
            pc_d       = id_pc_i;
            rs1_data_d = id_rs1_data_i;
            rs2_data_d = id_rs2_data_i;
            imm_d      = id_imm_i;
            rs1_addr_d = id_rs1_addr_i;
            rs2_addr_d = id_rs2_addr_i;
            rd_d       = id_rd_addr_i;
            srca_pc_d  = id_srca_pc_i;
            srcb_imm_d = id_srcb_imm_i;
            aluctrl_d  = id_aluctrl_i;
            flagsel_d  = id_flagsel_i;
            regwrite_d = id_regwrite_i;
            branch_d   = id_branch_i;
        end
    end

    // Pipeline register with asynchronous clear of every field
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            pc_q       <= {XLEN{1'b0}};
            rs1_data_q <= {XLEN{1'b0}};
            rs2_data_q <= {XLEN{1'b0}};
            imm_q      <= {XLEN{1'b0}};
            rs1_addr_q <= {RA_W{1'b0}};
            rs2_addr_q <= {RA_W{1'b0}};
            rd_q       <= {RA_W{1'b0}};
            srca_pc_q  <= 1'b0;
            srcb_imm_q <= 1'b0;
            aluctrl_q  <= 4'b0000;
            flagsel_q  <= 3'b000;
            regwrite_q <= 1'b0;
            branch_q   <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_q       <= rd_d;
            srca_pc_q  <= srca_pc_d;
            srcb_imm_q <= srcb_imm_d;
            aluctrl_q  <= aluctrl_d;
            flagsel_q  <= flagsel_d;
            regwrite_q <= regwrite_d;
            branch_q   <= branch_d;
        end
    end

    // Operand muxing and bubble masking of the control outputs
    always_comb begin
        id_ready_o      = ~stall_i;
        ex_valid_o      = valid_q;
        ex_pc_o         = pc_q;
        ex_rd_o         = rd_q;
        ex_opa_o        = srca_pc_q  ? pc_q  : fwd_rs1_s;
        ex_opb_o        = srcb_imm_q ? imm_q : fwd_rs2_s;
        ex_store_data_o = fwd_rs2_s;
        if (valid_q) begin
            ex_regwrite_o = regwrite_q;
            ex_branch_o   = branch_q;
            ex_aluctrl_o  = aluctrl_q;
            ex_flagsel_o  = flagsel_q;
        end else begin
            // A bubble must look like a NOP to the ALU and writeback.
            ex_regwrite_o = 1'b0;
            ex_branch_o   = 1'b0;
            ex_aluctrl_o  = 4'b0000;
            ex_flagsel_o  = 3'b000;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        id_valid_i;
    logic        id_ready_o;
    logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic        id_srca_pc_i, id_srcb_imm_i;
    logic [3:0]  id_aluctrl_i;
    logic [2:0]  id_flagsel_i;
    logic        id_regwrite_i, id_branch_i;
    logic        exmem_regwrite_i;
    logic [4:0]  exmem_rd_i;
    logic [31:0] exmem_data_i;
    logic        memwb_regwrite_i;
    logic [4:0]  memwb_rd_i;
    logic [31:0] memwb_data_i;
    logic        stall_i, flush_i;
    logic        ex_valid_o;
    logic [31:0] ex_opa_o, ex_opb_o, ex_store_data_o, ex_pc_o;
    logic [3:0]  ex_aluctrl_o;
    logic [2:0]  ex_flagsel_o;
    logic [4:0]  ex_rd_o;
    logic        ex_regwrite_o, ex_branch_o;

    int checks = 0;
    int errors = 0;

    id_ex_pipe #(.XLEN(32), .RA_W(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rd_addr_i(id_rd_addr_i), .id_srca_pc_i(id_srca_pc_i), .id_srcb_imm_i(id_srcb_imm_i),
        .id_aluctrl_i(id_aluctrl_i), .id_flagsel_i(id_flagsel_i),
        .id_regwrite_i(id_regwrite_i), .id_branch_i(id_branch_i),
        .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
        .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_opa_o(ex_opa_o), .ex_opb_o(ex_opb_o),
        .ex_store_data_o(ex_store_data_o), .ex_aluctrl_o(ex_aluctrl_o),
        .ex_flagsel_o(ex_flagsel_o), .ex_pc_o(ex_pc_o), .ex_rd_o(ex_rd_o),
        .ex_regwrite_o(ex_regwrite_o), .ex_branch_o(ex_branch_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        id_valid_i = 1'b0; id_pc_i = 32'h0; id_rs1_data_i = 32'h0; id_rs2_data_i = 32'h0;
        id_imm_i = 32'h0; id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; id_rd_addr_i = 5'd0;
        id_srca_pc_i = 1'b0; id_srcb_imm_i = 1'b0; id_aluctrl_i = 4'b0000; id_flagsel_i = 3'b000;
        id_regwrite_i = 1'b0; id_branch_i = 1'b0;
        exmem_regwrite_i = 1'b0; exmem_rd_i = 5'd0; exmem_data_i = 32'h0;
        memwb_regwrite_i = 1'b0; memwb_rd_i = 5'd0; memwb_data_i = 32'h0;
        stall_i = 1'b0; flush_i = 1'b0;

        // Reset state
        @(negedge clk_i); @(negedge clk_i);
        check("rst_valid", 32'(ex_valid_o), 32'h0);
        check("rst_opa", ex_opa_o, 32'h0);
        check("rst_aluctrl", 32'(ex_aluctrl_o), 32'h0);
        check("rst_ready", 32'(id_ready_o), 32'h1);
        rst_ni = 1'b1;

        // 1. Load ADD x5 = x1 + x2
        id_valid_i = 1'b1; id_pc_i = 32'h40;
        id_rs1_addr_i = 5'd1; id_rs1_data_i = 32'd5;
        id_rs2_addr_i = 5'd2; id_rs2_data_i = 32'd7;
        id_rd_addr_i = 5'd5; id_regwrite_i = 1'b1; id_aluctrl_i = 4'b0000;
        @(posedge clk_i); @(negedge clk_i);
        check("ld_valid", 32'(ex_valid_o), 32'h1);
        check("ld_opa", ex_opa_o, 32'd5);
        check("ld_opb", ex_opb_o, 32'd7);
        check("ld_regwrite", 32'(ex_regwrite_o), 32'h1);
        check("ld_rd", 32'(ex_rd_o), 32'd5);
        check("ld_store", ex_store_data_o, 32'd7);
        check("ld_pc", ex_pc_o, 32'h40);

        // 2. Forward priority on rs1 = x3
        id_rs1_addr_i = 5'd3; id_rs1_data_i = 32'd1;
        @(posedge clk_i); @(negedge clk_i);
        check("fw_none", ex_opa_o, 32'd1);
        exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd3; exmem_data_i = 32'hAA;
        memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd3; memwb_data_i = 32'hBB;
        #1 check("fw_exmem_prio", ex_opa_o, 32'hAA);
        check("fw_opb_untouched", ex_opb_o, 32'd7);
        exmem_regwrite_i = 1'b0;
        #1 check("fw_memwb", ex_opa_o, 32'hBB);
        exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd0; memwb_rd_i = 5'd0;
        #1 check("fw_x0_never", ex_opa_o, 32'd1);
        exmem_regwrite_i = 1'b0; memwb_regwrite_i = 1'b0;

        // 3. Refresh under a 3-cycle stall, rs2 = x4 stored 0
        @(negedge clk_i);
        id_rs1_addr_i = 5'd1; id_rs1_data_i = 32'h10;
        id_rs2_addr_i = 5'd4; id_rs2_data_i = 32'h0;
        @(posedge clk_i); @(negedge clk_i);
        check("st_pre_opb", ex_opb_o, 32'h0);
        stall_i = 1'b1; id_pc_i = 32'h999;
        memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd4; memwb_data_i = 32'h1234;
        #1 check("st_c1_opb", ex_opb_o, 32'h1234);
        check("st_ready", 32'(id_ready_o), 32'h0);
        @(posedge clk_i); @(negedge clk_i);
        memwb_regwrite_i = 1'b0; memwb_rd_i = 5'd0; id_rs2_data_i = 32'hDEAD;
        #1 check("st_c2_opb", ex_opb_o, 32'h1234);
        check("st_c2_pc_hold", ex_pc_o, 32'h40);
        check("st_c2_store", ex_store_data_o, 32'h1234);
        @(posedge clk_i); @(negedge clk_i);
        check("st_c3_opb", ex_opb_o, 32'h1234);
        check("st_c3_opa", ex_opa_o, 32'h10);
        stall_i = 1'b0;
        #1 check("st_rel_opb", ex_opb_o, 32'h1234);
        check("st_rel_ready", 32'(id_ready_o), 32'h1);

        // 4. Flush wins over stall; incoming SUB/branch discarded
        flush_i = 1'b1; stall_i = 1'b1;
        id_valid_i = 1'b1; id_aluctrl_i = 4'b1000; id_branch_i = 1'b1; id_flagsel_i = 3'b001;
        @(posedge clk_i); @(negedge clk_i);
        check("fl_valid", 32'(ex_valid_o), 32'h0);
        check("fl_branch", 32'(ex_branch_o), 32'h0);
        check("fl_aluctrl", 32'(ex_aluctrl_o), 32'h0);
        check("fl_flagsel", 32'(ex_flagsel_o), 32'h0);
        check("fl_regwrite", 32'(ex_regwrite_o), 32'h0);
        flush_i = 1'b0; stall_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        check("fl_after_valid", 32'(ex_valid_o), 32'h1);
        check("fl_after_branch", 32'(ex_branch_o), 32'h1);
        check("fl_after_aluctrl", 32'(ex_aluctrl_o), 32'h8);
        check("fl_after_flagsel", 32'(ex_flagsel_o), 32'h1);

        // 5. AUIPC-style PC and immediate sources
        id_srca_pc_i = 1'b1; id_srcb_imm_i = 1'b1; id_pc_i = 32'h100; id_imm_i = 32'h2000;
        id_rs2_addr_i = 5'd7; id_rs2_data_i = 32'h55; id_branch_i = 1'b0;
        id_aluctrl_i = 4'b0000; id_flagsel_i = 3'b000;
        @(posedge clk_i); @(negedge clk_i);
        check("src_opa_pc", ex_opa_o, 32'h100);
        check("src_opb_imm", ex_opb_o, 32'h2000);
        check("src_store", ex_store_data_o, 32'h55);
        exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd7; exmem_data_i = 32'h77;
        #1 check("src_store_fwd", ex_store_data_o, 32'h77);
        check("src_opb_keep_imm", ex_opb_o, 32'h2000);
        exmem_regwrite_i = 1'b0; exmem_rd_i = 5'd0;

        // 6. Asynchronous reset between edges
        @(negedge clk_i);
        check("ar_pre_valid", 32'(ex_valid_o), 32'h1);
        #2 rst_ni = 1'b0;
        #1 check("ar_valid", 32'(ex_valid_o), 32'h0);
        check("ar_opa", ex_opa_o, 32'h0);
        check("ar_opb", ex_opb_o, 32'h0);
        check("ar_pc", ex_pc_o, 32'h0);
        check("ar_store", ex_store_data_o, 32'h0);
        check("ar_regwrite", 32'(ex_regwrite_o), 32'h0);
        check("ar_rd", 32'(ex_rd_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        check("ar_reload_valid", 32'(ex_valid_o), 32'h1);
        check("ar_reload_opa", ex_opa_o, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
